decode_stage: RTL and testbench

- RV32I instruction decode stage, directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and extracts the register addresses that drive the regfile read ports.
- Generates the sign-extended immediate and write-enable, and holds the result in one pipeline register for execute.
- A 32-entry pending-write scoreboard stalls any instruction whose source register is still awaiting writeback.

---
 rtl/decode_stage.sv | 185 ++++++++++++++++++
 tb/tb_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes fetched instructions into a one-entry execute register
// and stalls any source register that still has a write pending in the scoreboard.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            instr_ready_o,
    output logic            ex_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      ex_rd_addr_o,
    output logic            ex_rd_wren_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [6:0]      ex_opcode_o,
    output logic [2:0]      ex_funct3_o,
    output logic [6:0]      ex_funct7_o,
    output logic            ex_illegal_o,
    input  logic            wb_wren_i,
    input  logic [4:0]      wb_addr_i,
    input  logic            flush_i
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]      op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            wr_type;
    logic            use_rs1;
    logic            use_rs2;
    logic            illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    logic            dec_wren;
    logic            hazard;
    logic            accept;

    logic [NREGS-1:0] pend_q, pend_d;
    logic             ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]  ex_pc_q;
    logic [4:0]       ex_rs1_q;
    logic [4:0]       ex_rs2_q;
    logic [4:0]       ex_rd_q;
    logic             ex_rd_wren_q;
    logic [XLEN-1:0]  ex_imm_q;
    logic [6:0]       ex_opcode_q;
    logic [2:0]       ex_funct3_q;
    logic [6:0]       ex_funct7_q;
    logic             ex_illegal_q;

    assign op  = instr_i[6:0];
    assign rd  = instr_i[11:7];
    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];

    always_comb begin
        wr_type = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        illegal = 1'b0;
        imm32   = '0;
        if (instr_i[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (op)
                OP_LUI, OP_AUIPC: begin
                    wr_type = 1'b1;
                    imm32   = {instr_i[31:12], 12'b0};
                end
                OP_JAL: begin
                    wr_type = 1'b1;
                    imm32   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                               instr_i[20], instr_i[30:21], 1'b0};
                end
                OP_JALR, OP_LOAD, OP_IMM: begin
                    wr_type = 1'b1;
                    use_rs1 = 1'b1;
                    imm32   = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                OP_BRANCH: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    imm32   = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                               instr_i[30:25], instr_i[11:8], 1'b0};
                end
                OP_STORE: begin
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                    imm32   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                end
                OP_OP: begin
                    wr_type = 1'b1;
                    use_rs1 = 1'b1;
                    use_rs2 = 1'b1;
                end
                OP_FENCE, OP_SYSTEM: ;
                default: illegal = 1'b1;
            endcase
        end
    end

    assign imm_ext  = XLEN'($signed(imm32));
    assign dec_wren = wr_type && (rd != 5'd0);

    // Registered scoreboard only: a stall releases the cycle after the clearing writeback.
    assign hazard = (use_rs1 && (rs1 != 5'd0) && pend_q[rs1]) ||
                    (use_rs2 && (rs2 != 5'd0) && pend_q[rs2]);

    assign instr_ready_o = !rst_i && !flush_i && !hazard && (!ex_valid_q || ex_ready_i);
    assign accept        = instr_valid_i && instr_ready_o;

    always_comb begin
        pend_d = pend_q;
        if (flush_i && ex_valid_q && ex_rd_wren_q) pend_d[ex_rd_q] = 1'b0;
        if (wb_wren_i && (wb_addr_i != 5'd0)) pend_d[wb_addr_i] = 1'b0;
        if (accept && dec_wren) pend_d[rd] = 1'b1;
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        if (accept) ex_valid_d = 1'b1;
        else if (flush_i || ex_ready_i) ex_valid_d = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q       <= '0;
            ex_valid_q   <= 1'b0;
            ex_pc_q      <= '0;
            ex_rs1_q     <= '0;
            ex_rs2_q     <= '0;
            ex_rd_q      <= '0;
            ex_rd_wren_q <= 1'b0;
            ex_imm_q     <= '0;
            ex_opcode_q  <= '0;
            ex_funct3_q  <= '0;
            ex_funct7_q  <= '0;
            ex_illegal_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            ex_valid_q <= ex_valid_d;
            if (accept) begin
                ex_pc_q      <= pc_i;
                ex_rs1_q     <= rs1;
                ex_rs2_q     <= rs2;
                ex_rd_q      <= rd;
                ex_rd_wren_q <= dec_wren;
                ex_imm_q     <= imm_ext;
                ex_opcode_q  <= op;
                ex_funct3_q  <= instr_i[14:12];
                ex_funct7_q  <= instr_i[31:25];
                ex_illegal_q <= illegal;
            end
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_pc_o      = ex_pc_q;
    assign rs1_addr_o   = ex_rs1_q;
    assign rs2_addr_o   = ex_rs2_q;
    assign ex_rd_addr_o = ex_rd_q;
    assign ex_rd_wren_o = ex_valid_q && ex_rd_wren_q;
    assign ex_imm_o     = ex_imm_q;
    assign ex_opcode_o  = ex_opcode_q;
    assign ex_funct3_o  = ex_funct3_q;
    assign ex_funct7_o  = ex_funct7_q;
    assign ex_illegal_o = ex_valid_q && ex_illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed test-plan sequences then random traffic,
// checked against an instruction-level reference model.
module tb_decode_stage;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        instr_valid_i = 1'b0;
    logic [31:0] instr_i = '0;
    logic [31:0] pc_i = '0;
    logic        instr_ready_o;
    logic        ex_valid_o;
    logic        ex_ready_i = 1'b0;
    logic [31:0] ex_pc_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, ex_rd_addr_o;
    logic        ex_rd_wren_o;
    logic [31:0] ex_imm_o;
    logic [6:0]  ex_opcode_o;
    logic [2:0]  ex_funct3_o;
    logic [6:0]  ex_funct7_o;
    logic        ex_illegal_o;
    logic        wb_wren_i = 1'b0;
    logic [4:0]  wb_addr_i = '0;
    logic        flush_i = 1'b0;

    always #5 clk_i = ~clk_i;

    decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_valid_i(instr_valid_i), .instr_i(instr_i), .pc_i(pc_i),
        .instr_ready_o(instr_ready_o),
        .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i), .ex_pc_o(ex_pc_o),
        .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
        .ex_rd_wren_o(ex_rd_wren_o), .ex_imm_o(ex_imm_o), .ex_opcode_o(ex_opcode_o),
        .ex_funct3_o(ex_funct3_o), .ex_funct7_o(ex_funct7_o), .ex_illegal_o(ex_illegal_o),
        .wb_wren_i(wb_wren_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        wren;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ill;
        logic        use1, use2;
    } item_t;

    item_t q[$];
    bit    pend[32];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [31:0] bits(logic [31:0] w, int lo, int n);
        return (w >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference decode: field meaning taken straight from the RV32I encodings.
    function automatic item_t ref_decode(logic [31:0] ins, logic [31:0] pc);
        item_t it;
        int    v;
        bit    s;
        s       = ins[31];
        v       = 0;
        it.pc   = pc;
        it.rs1  = ins[19:15];
        it.rs2  = ins[24:20];
        it.rd   = ins[11:7];
        it.op   = ins[6:0];
        it.f3   = ins[14:12];
        it.f7   = ins[31:25];
        it.wren = 1'b0;
        it.ill  = 1'b0;
        it.use1 = 1'b0;
        it.use2 = 1'b0;
        if (ins[1:0] != 2'b11) it.ill = 1'b1;
        else case (ins[6:0])
            7'b0110111, 7'b0010111: begin
                it.wren = 1'b1;
                v = int'(ins & 32'hFFFF_F000);
            end
            7'b1101111: begin
                it.wren = 1'b1;
                v = int'((bits(ins, 31, 1) << 20) | (bits(ins, 12, 8) << 12) |
                         (bits(ins, 20, 1) << 11) | (bits(ins, 21, 10) << 1));
                if (s) v = v - (1 << 21);
            end
            7'b1100111, 7'b0000011, 7'b0010011: begin
                it.wren = 1'b1;
                it.use1 = 1'b1;
                v = int'(bits(ins, 20, 12));
                if (s) v = v - 4096;
            end
            7'b1100011: begin
                it.use1 = 1'b1;
                it.use2 = 1'b1;
                v = int'((bits(ins, 31, 1) << 12) | (bits(ins, 7, 1) << 11) |
                         (bits(ins, 25, 6) << 5) | (bits(ins, 8, 4) << 1));
                if (s) v = v - 8192;
            end
            7'b0100011: begin
                it.use1 = 1'b1;
                it.use2 = 1'b1;
                v = int'((bits(ins, 25, 7) << 5) | bits(ins, 7, 5));
                if (s) v = v - 4096;
            end
            7'b0110011: begin
                it.wren = 1'b1;
                it.use1 = 1'b1;
                it.use2 = 1'b1;
            end
            7'b0001111, 7'b1110011: ;
            default: it.ill = 1'b1;
        endcase
        if (it.rd == 5'd0) it.wren = 1'b0;
        it.imm = v;
        return it;
    endfunction

    // One clock cycle: drive inputs, check handshake, advance the reference model.
    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit rdy, input bit wbe, input logic [4:0] wba,
                       input bit fl, input bit rs, output bit acc);
        item_t d;
        bit    held, haz, exp_rdy;
        @(posedge clk_i);
        #1;
        instr_valid_i = v;
        instr_i       = ins;
        pc_i          = pc;
        ex_ready_i    = rdy;
        wb_wren_i     = wbe;
        wb_addr_i     = wba;
        flush_i       = fl;
        rst_i         = rs;
        #1;
        held    = (q.size() > 0);
        d       = ref_decode(ins, pc);
        haz     = (d.use1 && d.rs1 != 0 && pend[d.rs1]) || (d.use2 && d.rs2 != 0 && pend[d.rs2]);
        exp_rdy = !rs && !fl && !haz && (!held || rdy);
        checks++;
        if (instr_ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL ready t=%0t instr=%h got %0b want %0b", $time, ins, instr_ready_o, exp_rdy);
        end
        checks++;
        if (ex_valid_o !== held || (!held && (ex_rd_wren_o || ex_illegal_o))) begin
            errors++;
            $display("FAIL ex_valid t=%0t got valid=%0b wren=%0b ill=%0b want valid=%0b",
                     $time, ex_valid_o, ex_rd_wren_o, ex_illegal_o, held);
        end
        acc = v && exp_rdy;
        if (rs) begin
            q.delete();
            foreach (pend[i]) pend[i] = 1'b0;
        end else begin
            if (fl && held && q[0].wren) pend[q[0].rd] = 1'b0;
            if (wbe && wba != 0) pend[wba] = 1'b0;
            if (acc) begin
                q.push_back(d);
                if (d.wren) pend[d.rd] = 1'b1;
            end
        end
    endtask

    task automatic offer(input logic [31:0] ins, input logic [31:0] pc, input bit rdy);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 10 && !acc; n++) cyc(1, ins, pc, rdy, 0, 0, 0, 0, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL offer_timeout instr=%h got no accept want accept", ins);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 1, 0, 0, 0, 0, acc);
    endtask

    // Monitor: compares every held instruction with the queue head, pops on consume/flush.
    always @(negedge clk_i) begin
        if (!rst_i && ex_valid_o) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL ex_unexpected t=%0t got pc=%h want nothing held", $time, ex_pc_o);
            end else begin
                if (ex_pc_o !== q[0].pc || rs1_addr_o !== q[0].rs1 || rs2_addr_o !== q[0].rs2 ||
                    ex_rd_addr_o !== q[0].rd || ex_rd_wren_o !== q[0].wren ||
                    ex_imm_o !== q[0].imm || ex_opcode_o !== q[0].op ||
                    ex_funct3_o !== q[0].f3 || ex_funct7_o !== q[0].f7 ||
                    ex_illegal_o !== q[0].ill) begin
                    errors++;
                    $display("FAIL ex_fields t=%0t got pc=%h rs1=%0d rs2=%0d rd=%0d wr=%0b imm=%h op=%b f3=%0d f7=%h ill=%0b want pc=%h rs1=%0d rs2=%0d rd=%0d wr=%0b imm=%h op=%b f3=%0d f7=%h ill=%0b",
                             $time, ex_pc_o, rs1_addr_o, rs2_addr_o, ex_rd_addr_o, ex_rd_wren_o,
                             ex_imm_o, ex_opcode_o, ex_funct3_o, ex_funct7_o, ex_illegal_o,
                             q[0].pc, q[0].rs1, q[0].rs2, q[0].rd, q[0].wren, q[0].imm,
                             q[0].op, q[0].f3, q[0].f7, q[0].ill);
                end
                if (ex_ready_i || flush_i) void'(q.pop_front());
            end
        end
    end

    logic [6:0] ops [11] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                             7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111,
                             7'b1110011};

    initial begin
        bit          acc;
        logic [31:0] ins;
        bit          pat [4] = '{1, 0, 1, 1};
        int          idx, c;

        cyc(0, 0, 0, 0, 0, 0, 0, 1, acc);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, acc);
        idle(1);

        // ADDI x5,x0,-1 then dependent ADD x6,x5,x1 held off until x5 writeback
        cyc(1, 32'hFFF00293, 32'h100, 1, 0, 0, 0, 0, acc);
        for (int k = 0; k < 3; k++) cyc(1, 32'h00128333, 32'h104, 1, 0, 0, 0, 0, acc);
        cyc(1, 32'h00128333, 32'h104, 1, 1, 5'd5, 0, 0, acc);
        cyc(1, 32'h00128333, 32'h104, 1, 0, 0, 0, 0, acc);
        idle(1);

        // Four independent ADDIs with execute ready pattern 1,0,1,1
        idx = 0;
        c   = 0;
        while (idx < 4 && c < 20) begin
            ins = {12'(idx + 1), 5'd0, 3'd0, 5'(10 + idx), 7'b0010011};
            cyc(1, ins, 32'h200 + 32'(4 * idx), pat[c % 4], 0, 0, 0, 0, acc);
            if (acc) idx++;
            c++;
        end
        checks++;
        if (idx != 4) begin
            errors++;
            $display("FAIL stream_accepts got %0d want 4", idx);
        end
        idle(2);
        for (int r = 1; r < 32; r++) cyc(0, 0, 0, 1, 1, 5'(r), 0, 0, acc);

        // Immediate formats, illegal word, write to x0
        offer(32'hFE112E23, 32'h300, 1);
        offer(32'hFE000EE3, 32'h304, 1);
        offer(32'h123450B7, 32'h308, 1);
        offer(32'hFF9FF0EF, 32'h30C, 1);
        offer(32'h00000000, 32'h310, 1);
        offer(32'h00000013, 32'h314, 1);
        idle(2);

        // Flush a held ADDI x7: its pending bit must drop so a reader of x7 goes straight in
        offer(32'h00000393, 32'h400, 0);
        cyc(1, 32'h00038433, 32'h404, 0, 0, 0, 1, 0, acc);
        cyc(1, 32'h00038433, 32'h404, 1, 0, 0, 0, 0, acc);
        idle(2);

        // Reset during a stall on x9
        offer(32'h00000493, 32'h500, 0);
        cyc(1, 32'h00048433, 32'h504, 0, 0, 0, 0, 0, acc);
        cyc(1, 32'h00048433, 32'h504, 0, 0, 0, 0, 1, acc);
        cyc(1, 32'h00048433, 32'h504, 1, 0, 0, 0, 0, acc);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = $urandom_range(0, 12);
            ins = $urandom;
            if (sel < 11) begin
                ins[6:0]   = ops[sel];
                ins[11:7]  = 5'($urandom_range(0, 7));
                ins[19:15] = 5'($urandom_range(0, 7));
                ins[24:20] = 5'($urandom_range(0, 7));
            end
            cyc($urandom_range(0, 9) < 8, ins, $urandom, $urandom_range(0, 9) < 7,
                $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)),
                $urandom_range(0, 99) < 5, $urandom_range(0, 199) == 0, acc);
        end
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
